// File: rtl/plants_rom_arbiter.sv
// plants_rom_arbiter: shares the plants sprite ROM among NUM_REQ sprite layers.
// Two-class round-robin grant, registered ROM address, and a tag pipeline that
// returns each read with the requester index 2+ROM_LAT cycles after the grant.
module plants_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 7,
  parameter int ROM_LAT = 0,
  parameter logic [NUM_REQ-1:0] HIPRI_MASK = {{(NUM_REQ-1){1'b0}}, 1'b1},
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rd_valid,
  output logic [ID_W-1:0]           rd_id,
  output logic [DATA_W-1:0]         rd_data
);

  // One tag stage per cycle of ROM latency, plus the stage that lines up with
  // the registered rom_addr.
  localparam int NSTG = ROM_LAT + 1;

  logic [ID_W-1:0]            hi_ptr;
  logic [ID_W-1:0]            lo_ptr;
  logic [NUM_REQ-1:0]         hi_req;
  logic [NUM_REQ-1:0]         lo_req;
  logic [NUM_REQ-1:0]         cls_req;
  logic                       use_hi;
  logic [ID_W-1:0]            start;
  logic [ID_W-1:0]            cand_idx;
  int                         cand;
  logic                       gnt_any;
  logic [ID_W-1:0]            gnt_idx;
  logic [ID_W-1:0]            gnt_next;
  logic [NSTG-1:0]            stg_v;
  logic [NSTG-1:0][ID_W-1:0]  stg_id;

  // Pick the class (high wins if any high request), then search round-robin
  // from that class's pointer; no grant is ever issued while in reset.
  always_comb begin
    hi_req   = req & HIPRI_MASK;
    lo_req   = req & ~HIPRI_MASK;
    use_hi   = |hi_req;
    cls_req  = use_hi ? hi_req : lo_req;
    start    = use_hi ? hi_ptr : lo_ptr;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(start) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!gnt_any && cls_req[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    gnt_next = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
    if (gnt_any && reset_n) gnt[gnt_idx] = 1'b1;
  end

  // Advance only the pointer of the class that won this cycle.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hi_ptr <= '0;
      lo_ptr <= '0;
    end else if (gnt_any) begin
      if (use_hi) hi_ptr <= gnt_next;
      else        lo_ptr <= gnt_next;
    end
  end

  // Launch the granted address to the ROM; hold it when idle.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) rom_addr <= '0;
    else if (gnt_any) rom_addr <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
  end

  // Tag pipeline: bubbles enter when there is no grant, reset drops everything in flight.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      stg_v  <= '0;
      stg_id <= '0;
    end else begin
      stg_v[0]  <= gnt_any;
      stg_id[0] <= gnt_idx;
      for (int s = 1; s < NSTG; s++) begin
        stg_v[s]  <= stg_v[s-1];
        stg_id[s] <= stg_id[s-1];
      end
    end
  end

  // Capture ROM data when the tag reaches the last stage; id/data hold otherwise.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= stg_v[NSTG-1];
      if (stg_v[NSTG-1]) begin
        rd_id   <= stg_id[NSTG-1];
        rd_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_plants_rom_arbiter.sv
// Bench for plants_rom_arbiter: three instances (default mask, mask 0, mask 0
// with a 2-cycle ROM) share one stimulus and are checked every cycle against a
// schedule-based model, plus hand-computed literal expectations per test.
module tb_plants_rom_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_addr = '0;

  logic [3:0]  gnt_a, gnt_b, gnt_c;
  logic [15:0] rom_addr_a, rom_addr_b, rom_addr_c;
  logic [6:0]  rom_q_a, rom_q_b, rom_q_c;
  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic [1:0]  rd_id_a, rd_id_b, rd_id_c;
  logic [6:0]  rd_data_a, rd_data_b, rd_data_c;
  logic [15:0] dl1, dl2;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  function automatic logic [6:0] rom_f(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd3 + (a >> 8);
    return t[6:0];
  endfunction

  assign rom_q_a = rom_f(rom_addr_a);
  assign rom_q_b = rom_f(rom_addr_b);
  always @(posedge vga_clk) begin
    dl1 <= rom_addr_c;
    dl2 <= dl1;
  end
  assign rom_q_c = rom_f(dl2);

  plants_rom_arbiter #(.HIPRI_MASK(4'b0001)) u_a (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a),
    .rd_valid(rd_valid_a), .rd_id(rd_id_a), .rd_data(rd_data_a));

  plants_rom_arbiter #(.HIPRI_MASK(4'b0000)) u_b (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt_b), .rom_addr(rom_addr_b), .rom_q(rom_q_b),
    .rd_valid(rd_valid_b), .rd_id(rd_id_b), .rd_data(rd_data_b));

  plants_rom_arbiter #(.HIPRI_MASK(4'b0000), .ROM_LAT(2)) u_c (
    .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt_c), .rom_addr(rom_addr_c), .rom_q(rom_q_c),
    .rd_valid(rd_valid_c), .rd_id(rd_id_c), .rd_data(rd_data_c));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] mask_of(input int m);
    return (m == 0) ? 4'b0001 : 4'b0000;
  endfunction

  function automatic int lat_of(input int m);
    return (m == 2) ? 2 : 0;
  endfunction

  // Winner by the class/round-robin rule, -1 if nobody is requesting.
  function automatic int arb(input logic [3:0] r, input logic [3:0] mask,
                             input int hp, input int lp);
    logic [3:0] cls;
    logic [1:0] b;
    int p;
    if ((r & mask) != 4'b0000) begin cls = r & mask;  p = hp; end
    else                       begin cls = r & ~mask; p = lp; end
    for (int k = 0; k < 4; k++) begin
      b = 2'((p + k) % 4);
      if (cls[b]) return (p + k) % 4;
    end
    return -1;
  endfunction

  int   cyc = 0;
  int   hp [3];
  int   lp [3];
  logic mv [3];
  int   mid [3];
  int   mdat [3];
  int   maddr [3];
  logic sv [3][64];
  int   sid [3][64];
  int   sdat [3][64];
  int   w, s, slot;
  logic [3:0]  g, eg;
  logic [15:0] ra, ga;
  logic        v;
  logic [1:0]  id;
  logic [6:0]  d;

  initial begin
    for (int m = 0; m < 3; m++) begin
      hp[m] = 0; lp[m] = 0; mv[m] = 1'b0; mid[m] = 0; mdat[m] = 0; maddr[m] = 0;
      for (int k = 0; k < 64; k++) begin sv[m][k] = 1'b0; sid[m][k] = 0; sdat[m][k] = 0; end
    end
  end

  // Compare every instance against the model mid-cycle, then advance the model
  // to the state it must have after the coming posedge.
  always @(negedge vga_clk) begin
    for (int m = 0; m < 3; m++) begin
      case (m)
        0:       begin g = gnt_a; ra = rom_addr_a; v = rd_valid_a; id = rd_id_a; d = rd_data_a; end
        1:       begin g = gnt_b; ra = rom_addr_b; v = rd_valid_b; id = rd_id_b; d = rd_data_b; end
        default: begin g = gnt_c; ra = rom_addr_c; v = rd_valid_c; id = rd_id_c; d = rd_data_c; end
      endcase
      w  = reset_n ? arb(req, mask_of(m), hp[m], lp[m]) : -1;
      eg = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk($sformatf("model_gnt[%0d]", m), int'(g), int'(eg));
      chk($sformatf("model_rom_addr[%0d]", m), int'(ra), maddr[m]);
      chk($sformatf("model_rd_valid[%0d]", m), int'(v), int'(mv[m]));
      chk($sformatf("model_rd_id[%0d]", m), int'(id), mid[m]);
      chk($sformatf("model_rd_data[%0d]", m), int'(d), mdat[m]);
      if (!reset_n) begin
        hp[m] = 0; lp[m] = 0; mv[m] = 1'b0; mid[m] = 0; mdat[m] = 0; maddr[m] = 0;
        for (int k = 0; k < 64; k++) sv[m][k] = 1'b0;
      end else begin
        if (w >= 0) begin
          ga       = req_addr[w*16 +: 16];
          maddr[m] = int'(ga);
          slot     = (cyc + 2 + lat_of(m)) % 64;
          sv[m][slot]   = 1'b1;
          sid[m][slot]  = w;
          sdat[m][slot] = int'(rom_f(ga));
          if (mask_of(m)[w[1:0]]) hp[m] = (w + 1) % 4;
          else                    lp[m] = (w + 1) % 4;
        end
        s     = (cyc + 1) % 64;
        mv[m] = sv[m][s];
        if (sv[m][s]) begin mid[m] = sid[m][s]; mdat[m] = sdat[m][s]; end
        sv[m][s] = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  // Drive one cycle's inputs just after the posedge; return before the negedge
  // so the caller samples that cycle's outputs.
  task automatic step(input logic [3:0] r, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3);
    @(posedge vga_clk);
    #1;
    req      = r;
    req_addr = {a3, a2, a1, a0};
    #3;
  endtask

  task automatic rst();
    @(posedge vga_clk);
    #1;
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    #3;
  endtask

  int exp1 [6] = '{1, 2, 4, 8, 1, 2};
  int id1  [6] = '{0, 1, 2, 3, 0, 1};
  int exp3 [4] = '{2, 4, 8, 2};

  initial begin
    rst();

    // Test 1: round-robin among the low class (instance b)
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(4'b1111, 16'h1000, 16'h1001, 16'h1002, 16'h1003);
      else       step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      if (i < 6) chk("t1_gnt_order", int'(gnt_b), exp1[i]);
      if (i >= 2) chk("t1_rd_id_order", int'(rd_id_b), id1[i-2]);
      if (i >= 2) chk("t1_rd_valid", int'(rd_valid_b), 1);
      if (i == 2) chk("t1_rd_data_first", int'(rd_data_b), 16);
    end
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);

    // Test 2: single requester, new address each cycle
    rst();
    for (int i = 0; i < 11; i++) begin
      if (i < 8) step(4'b0100, 16'h0, 16'h0, 16'h0100 + 16'(i), 16'h0);
      else       step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      if (i < 8) chk("t2_gnt", int'(gnt_a), 4);
      if (i >= 1 && i <= 8) chk("t2_rom_addr_trail", int'(rom_addr_a), 16'h0100 + i - 1);
      if (i >= 2 && i <= 9) chk("t2_rd_id", int'(rd_id_a), 2);
    end

    // Test 3: high class wins, then low class round-robin from pointer 0
    rst();
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 16'h2000, 16'h2001, 16'h2002, 16'h2003);
      chk("t3_gnt_hi", int'(gnt_a), 1);
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b1110, 16'h2000, 16'h2001, 16'h2002, 16'h2003);
      chk("t3_gnt_lo", int'(gnt_a), exp3[i]);
    end
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);

    // Test 4: reset while a read is in flight
    rst();
    step(4'b0010, 16'h0, 16'h0040, 16'h0, 16'h0);
    chk("t4_gnt", int'(gnt_a), 2);
    @(posedge vga_clk);
    #1;
    reset_n = 1'b0;
    req     = '0;
    #3;
    chk("t4_gnt_in_reset", int'(gnt_a), 0);
    chk("t4_rd_valid_n1", int'(rd_valid_a), 0);
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    #3;
    for (int i = 2; i <= 5; i++) begin
      if (i > 2) step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      chk("t4_rd_valid_zero", int'(rd_valid_a), 0);
      chk("t4_rd_data_zero", int'(rd_data_a), 0);
      chk("t4_rd_id_zero", int'(rd_id_a), 0);
      chk("t4_rom_addr_zero", int'(rom_addr_a), 0);
    end
    step(4'b0010, 16'h0, 16'h0010, 16'h0, 16'h0);
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("t4_after_valid", int'(rd_valid_a), 1);
    chk("t4_after_id", int'(rd_id_a), 1);
    chk("t4_after_data", int'(rd_data_a), 48);

    // Test 5: 2-cycle ROM latency (instance c)
    rst();
    step(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0020);
    for (int k = 1; k <= 5; k++) begin
      step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      chk("t5_rd_valid_lat", int'(rd_valid_c), (k == 4) ? 1 : 0);
      if (k == 4) begin
        chk("t5_rd_data", int'(rd_data_c), 96);
        chk("t5_rd_id", int'(rd_id_c), 3);
      end
    end

    // Test 6: request, gap, request on requester 3
    rst();
    step(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0030);
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("t6_rom_addr_gap1", int'(rom_addr_a), 16'h0030);
    step(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0031);
    chk("t6_rom_addr_gap2", int'(rom_addr_a), 16'h0030);
    chk("t6_rd_valid_0", int'(rd_valid_a), 1);
    chk("t6_rd_data_0", int'(rd_data_a), 16);
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("t6_rd_valid_1", int'(rd_valid_a), 0);
    chk("t6_rd_data_hold", int'(rd_data_a), 16);
    chk("t6_rom_addr_new", int'(rom_addr_a), 16'h0031);
    step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("t6_rd_valid_2", int'(rd_valid_a), 1);
    chk("t6_rd_data_2", int'(rd_data_a), 19);
    for (int i = 0; i < 4; i++) step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
